// File: rtl/nes_joypad_responder_if.sv
// Joypad serial bus between the rp2a03 joypad controller (master) and the pad emulator (slave).
interface nes_joypad_responder_if;
   logic jp_latch_in;
   logic jp_clk_in;
   logic jp_data1_out;
   logic jp_data2_out;

   modport master (
      output jp_latch_in,
      output jp_clk_in,
      input  jp_data1_out,
      input  jp_data2_out
   );

   modport slave (
      input  jp_latch_in,
      input  jp_clk_in,
      output jp_data1_out,
      output jp_data2_out
   );
endinterface

// File: rtl/nes_joypad_responder.sv
// Emulates two 4021-based NES pads from parallel button vectors on the rp2a03 joypad bus.
// Optional turbo A/B masking is compiled in with `define JOYPAD_TURBO_EN.
module nes_joypad_responder #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter bit          SOCD_FILTER  = 1'b1,
   parameter logic        FILL_BIT     = 1'b1,
   parameter int unsigned TURBO_FRAMES = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [7:0]               btn1_in,
   input  logic [7:0]               btn2_in,
   nes_joypad_responder_if.slave    jp,
   output logic                     read_done_out
`ifdef JOYPAD_TURBO_EN
   ,
   input  logic [1:0]               turbo1_in,
   input  logic [1:0]               turbo2_in
`endif
);

   if (SYNC_STAGES < 2 || TURBO_FRAMES < 1) begin : g_param_check
      $error("nes_joypad_responder: SYNC_STAGES must be >= 2 and TURBO_FRAMES >= 1");
   end

   logic [SYNC_STAGES-1:0] latch_sync;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic                   latch_prev;
   logic                   clk_prev;
   logic [7:0]             sr1;
   logic [7:0]             sr2;
   logic [3:0]             bit_cnt;
   logic                   latch_now;
   logic                   clk_rise;
   logic [7:0]             cond1;
   logic [7:0]             cond2;

   assign latch_now = latch_sync[SYNC_STAGES-1];
   assign clk_rise  = clk_sync[SYNC_STAGES-1] & ~clk_prev;

   // Opposing directions pressed together read as neither pressed.
   function automatic logic [7:0] socd(input logic [7:0] b);
      logic [7:0] r;
      r = b;
      if (SOCD_FILTER) begin
         if (b[4] && b[5]) r[5:4] = 2'b00;
         if (b[6] && b[7]) r[7:6] = 2'b00;
      end
      return r;
   endfunction

`ifdef JOYPAD_TURBO_EN
   localparam int unsigned TCW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;

   logic [TCW-1:0] turbo_cnt;
   logic           turbo_phase;
   logic           latch_fall;

   assign latch_fall = latch_prev & ~latch_now;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         turbo_cnt   <= '0;
         turbo_phase <= 1'b0;
      end else if (latch_fall) begin
         if (turbo_cnt == TCW'(TURBO_FRAMES - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
         end else begin
            turbo_cnt <= turbo_cnt + TCW'(1);
         end
      end
   end

   // Turbo-enabled A/B read released during phase 0 and pass through in phase 1.
   always_comb begin
      cond1 = socd(btn1_in) & ~{6'b00_0000, turbo1_in & {2{~turbo_phase}}};
      cond2 = socd(btn2_in) & ~{6'b00_0000, turbo2_in & {2{~turbo_phase}}};
   end
`else
   always_comb begin
      cond1 = socd(btn1_in);
      cond2 = socd(btn2_in);
   end
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         latch_sync    <= '0;
         clk_sync      <= '0;
         latch_prev    <= 1'b0;
         clk_prev      <= 1'b0;
         sr1           <= '0;
         sr2           <= '0;
         bit_cnt       <= '0;
         read_done_out <= 1'b0;
      end else begin
         latch_sync    <= {latch_sync[SYNC_STAGES-2:0], jp.jp_latch_in};
         clk_sync      <= {clk_sync[SYNC_STAGES-2:0], jp.jp_clk_in};
         latch_prev    <= latch_now;
         clk_prev      <= clk_sync[SYNC_STAGES-1];
         read_done_out <= 1'b0;
         // Latch has priority: a clock edge seen while latched is swallowed by the reload.
         if (latch_now) begin
            sr1     <= cond1;
            sr2     <= cond2;
            bit_cnt <= '0;
         end else if (clk_rise) begin
            sr1 <= {FILL_BIT, sr1[7:1]};
            sr2 <= {FILL_BIT, sr2[7:1]};
            if (bit_cnt != 4'd8) begin
               bit_cnt <= bit_cnt + 4'd1;
            end
            read_done_out <= (bit_cnt == 4'd7);
         end
      end
   end

   assign jp.jp_data1_out = sr1[0];
   assign jp.jp_data2_out = sr2[0];

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Directed bench for nes_joypad_responder: default build plus a SOCD_FILTER=0 instance on the same bus.
`timescale 1ns/1ps
module tb_nes_joypad_responder;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic [7:0] btn1   = '0;
   logic [7:0] btn2   = '0;
   logic       jp_latch = 1'b0;
   logic       jp_clk   = 1'b0;
   logic       done_a;
   logic       done_b;
   int         done_cnt_a = 0;
   int         done_cnt_b = 0;
   int         checks   = 0;
   int         failures = 0;
`ifdef JOYPAD_TURBO_EN
   logic [1:0] turbo1 = '0;
   logic [1:0] turbo2 = '0;
`endif

   nes_joypad_responder_if jp_a ();
   nes_joypad_responder_if jp_b ();

   assign jp_a.jp_latch_in = jp_latch;
   assign jp_a.jp_clk_in   = jp_clk;
   assign jp_b.jp_latch_in = jp_latch;
   assign jp_b.jp_clk_in   = jp_clk;

   nes_joypad_responder dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .btn1_in       (btn1),
      .btn2_in       (btn2),
      .jp            (jp_a),
      .read_done_out (done_a)
`ifdef JOYPAD_TURBO_EN
      ,
      .turbo1_in     (turbo1),
      .turbo2_in     (turbo2)
`endif
   );

   nes_joypad_responder #(.SOCD_FILTER(1'b0)) dut_nosocd (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .btn1_in       (btn1),
      .btn2_in       (btn2),
      .jp            (jp_b),
      .read_done_out (done_b)
`ifdef JOYPAD_TURBO_EN
      ,
      .turbo1_in     (2'b00),
      .turbo2_in     (2'b00)
`endif
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (done_a === 1'b1) done_cnt_a++;
      if (done_b === 1'b1) done_cnt_b++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic pulse();
      @(negedge clk_in);
      jp_clk = 1'b1;
      tick(4);
      @(negedge clk_in);
      jp_clk = 1'b0;
      tick(4);
   endtask

   task automatic latch_frame();
      @(negedge clk_in);
      jp_latch = 1'b1;
      tick(4);
      @(negedge clk_in);
      jp_latch = 1'b0;
      tick(4);
   endtask

   // Reads 8 bits from both instances, checking read_done only on the 8th shift.
   task automatic read8(input string tag, input logic [7:0] ea1, input logic [7:0] ea2,
                        input logic [7:0] eb1, input logic [7:0] eb2);
      int start;
      start = done_cnt_a;
      for (int unsigned i = 0; i < 8; i++) begin
         check($sformatf("%s_a1_b%0d", tag, i), {7'd0, jp_a.jp_data1_out}, {7'd0, ea1[i]});
         check($sformatf("%s_a2_b%0d", tag, i), {7'd0, jp_a.jp_data2_out}, {7'd0, ea2[i]});
         check($sformatf("%s_b1_b%0d", tag, i), {7'd0, jp_b.jp_data1_out}, {7'd0, eb1[i]});
         check($sformatf("%s_b2_b%0d", tag, i), {7'd0, jp_b.jp_data2_out}, {7'd0, eb2[i]});
         if (i == 7) check($sformatf("%s_nodone7", tag), 8'(done_cnt_a - start), 8'd0);
         pulse();
      end
      check($sformatf("%s_done8", tag), 8'(done_cnt_a - start), 8'd1);
   endtask

   typedef struct {
      logic [7:0] b1, b2, ea1, ea2, eb1, eb2;
   } socd_vec_t;

   socd_vec_t socd_tbl [3] = '{
      '{8'h30, 8'h5A, 8'h00, 8'h5A, 8'h30, 8'h5A},
      '{8'hC1, 8'hF0, 8'h01, 8'h00, 8'hC1, 8'hF0},
      '{8'hB6, 8'h4C, 8'h86, 8'h4C, 8'hB6, 8'h4C}
   };

`ifdef JOYPAD_TURBO_EN
   logic [4:0] turbo_exp = 5'b01100;
`endif

   initial begin
      // Reset state
      rst_in = 1'b1;
      tick(3);
      check("rst_d1", {7'd0, jp_a.jp_data1_out}, 8'd0);
      check("rst_d2", {7'd0, jp_a.jp_data2_out}, 8'd0);
      check("rst_done", {7'd0, done_a}, 8'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      tick(2);

      // Shifting without a latch: zeros only, no done pulse
      for (int unsigned i = 0; i < 3; i++) begin
         pulse();
         check($sformatf("nolatch_d1_%0d", i), {7'd0, jp_a.jp_data1_out}, 8'd0);
         check($sformatf("nolatch_d2_%0d", i), {7'd0, jp_a.jp_data2_out}, 8'd0);
      end
      check("nolatch_done", 8'(done_cnt_a), 8'd0);

      // Main read; buttons change during shift and must be ignored
      btn1 = 8'h85;
      btn2 = 8'h00;
      latch_frame();
      btn1 = 8'hFF;
      btn2 = 8'h0F;
      // Latency: data moves on the 3rd clk_in edge after jp_clk rises
      check("lat_before", {7'd0, jp_a.jp_data1_out}, 8'd1);
      @(negedge clk_in);
      jp_clk = 1'b1;
      tick(2);
      check("lat_edge2", {7'd0, jp_a.jp_data1_out}, 8'd1);
      tick(1);
      check("lat_edge3", {7'd0, jp_a.jp_data1_out}, 8'd0);
      tick(1);
      @(negedge clk_in);
      jp_clk = 1'b0;
      tick(4);
      for (int unsigned i = 1; i < 8; i++) begin
         check($sformatf("main_d1_b%0d", i), {7'd0, jp_a.jp_data1_out}, {7'd0, 8'h85 >> i} & 8'd1);
         check($sformatf("main_d2_b%0d", i), {7'd0, jp_a.jp_data2_out}, 8'd0);
         if (i == 7) check("main_nodone7", 8'(done_cnt_a), 8'd0);
         pulse();
      end
      check("main_done8", 8'(done_cnt_a), 8'd1);

      // Past the 8th bit: FILL_BIT, counter saturates, no extra pulse
      for (int unsigned i = 0; i < 4; i++) begin
         check($sformatf("fill_d1_%0d", i), {7'd0, jp_a.jp_data1_out}, 8'd1);
         check($sformatf("fill_d2_%0d", i), {7'd0, jp_a.jp_data2_out}, 8'd1);
         pulse();
      end
      check("fill_done", 8'(done_cnt_a), 8'd1);

      // SOCD filter (dut) against unfiltered (dut_nosocd)
      foreach (socd_tbl[k]) begin
         btn1 = socd_tbl[k].b1;
         btn2 = socd_tbl[k].b2;
         latch_frame();
         read8($sformatf("socd%0d", k), socd_tbl[k].ea1, socd_tbl[k].ea2,
               socd_tbl[k].eb1, socd_tbl[k].eb2);
      end

      // Latch and clk rising together mid-read: reload wins
      btn1 = 8'h85;
      btn2 = 8'h00;
      latch_frame();
      pulse();
      pulse();
      pulse();
      check("mid_bit3", {7'd0, jp_a.jp_data1_out}, 8'd0);
      @(negedge clk_in);
      jp_latch = 1'b1;
      jp_clk   = 1'b1;
      tick(4);
      check("reload_d1", {7'd0, jp_a.jp_data1_out}, 8'd1);
      btn1 = 8'h84;
      btn2 = 8'h01;
      tick(4);
      check("load_live_d1", {7'd0, jp_a.jp_data1_out}, 8'd0);
      check("load_live_d2", {7'd0, jp_a.jp_data2_out}, 8'd1);
      @(negedge clk_in);
      jp_latch = 1'b0;
      tick(4);
      @(negedge clk_in);
      jp_clk = 1'b0;
      tick(4);
      read8("reload", 8'h84, 8'h01, 8'h84, 8'h01);

      // Reset mid-read
      btn1 = 8'h0F;
      btn2 = 8'h0F;
      latch_frame();
      pulse();
      check("prerst_d1", {7'd0, jp_a.jp_data1_out}, 8'd1);
      @(negedge clk_in);
      rst_in = 1'b1;
      tick(1);
      check("midrst_d1", {7'd0, jp_a.jp_data1_out}, 8'd0);
      check("midrst_d2", {7'd0, jp_a.jp_data2_out}, 8'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         pulse();
         check($sformatf("postrst_d1_%0d", i), {7'd0, jp_a.jp_data1_out}, 8'd0);
      end
      check("total_done_a", 8'(done_cnt_a), 8'd5);
      check("total_done_b", 8'(done_cnt_b), 8'd5);

`ifdef JOYPAD_TURBO_EN
      @(negedge clk_in);
      rst_in = 1'b1;
      tick(2);
      @(negedge clk_in);
      rst_in = 1'b0;
      btn1   = 8'h01;
      btn2   = 8'h01;
      turbo1 = 2'b01;
      turbo2 = 2'b00;
      for (int unsigned f = 0; f < 5; f++) begin
         latch_frame();
         check($sformatf("turbo_f%0d_d1", f + 1), {7'd0, jp_a.jp_data1_out}, {7'd0, turbo_exp[f]});
         check($sformatf("turbo_f%0d_d2", f + 1), {7'd0, jp_a.jp_data2_out}, 8'd1);
      end
      turbo1 = 2'b00;
      for (int unsigned f = 0; f < 2; f++) begin
         latch_frame();
         check($sformatf("noturbo_f%0d_d1", f), {7'd0, jp_a.jp_data1_out}, 8'd1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nes_joypad_responder.md
Name: nes_joypad_responder

Overview:
Device end of the NES joypad serial protocol. The rp2a03 joypad controller drives latch and clock and samples two data lines. This block emulates two standard 4021-based controllers from parallel button vectors, for example those decoded from PS/2 by the keyboard block. It replaces physical pads on boards without joypad connectors and drives the rp2a03 jp_data1_in/jp_data2_in inputs.

Parameters:
SYNC_STAGES, 2, flops in each latch/clk input synchronizer (min 2)
SOCD_FILTER, 1, 1 = opposing directions pressed together are both reported released
FILL_BIT, 1'b1, value shifted in behind the 8 buttons (official pads return 1 after the 8th read)
TURBO_FRAMES, 2, latch pulses per turbo phase (used only with JOYPAD_TURBO_EN)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-high
btn1_in  input  8  pad 1 buttons, 1 = pressed; bit0..7 = A,B,Select,Start,Up,Down,Left,Right
btn2_in  input  8  pad 2 buttons, same encoding
jp_latch_in  input  1  latch/strobe from rp2a03 (asynchronous to clk_in)
jp_clk_in  input  1  shift clock from rp2a03 (asynchronous to clk_in)
jp_data1_out  output  1  pad 1 serial data, 1 = pressed
jp_data2_out  output  1  pad 2 serial data, 1 = pressed
read_done_out  output  1  one-cycle pulse when the 8th button bit has been shifted out
turbo1_in  input  2  (JOYPAD_TURBO_EN only) bit0 turbo A, bit1 turbo B, pad 1
turbo2_in  input  2  (JOYPAD_TURBO_EN only) same, pad 2

Behaviour:
- One clock domain: clk_in. Reset is synchronous and active-high on rst_in.
- Reset:
  - Synchronizers, edge-detect flops and shift registers clear to 0.
  - Bit counter clears to 0. Turbo counter and phase clear to 0.
  - jp_data1_out = jp_data2_out = 0. read_done_out = 0.
- Synchronization: latch and clk each pass through SYNC_STAGES flops. A delayed copy of the last stage provides edge detection.
- Button conditioning (combinational on btnN_in before load):
  - If SOCD_FILTER = 1, Up and Down both set forces both to 0. Left and Right are handled the same way.
  - Turbo masking is then applied, when the feature is compiled in.
- LOAD state (synced latch = 1):
  - Each cycle, sr1/sr2 load the conditioned vectors and the bit counter is set to 0.
  - Data outputs track bit0 (A) live.
- SHIFT state (synced latch = 0):
  - On a synced clk rising edge, sr <= {FILL_BIT, sr[7:1]} for both pads and the counter increments, saturating at 8.
  - When the counter goes from 7 to 8, read_done_out pulses for 1 cycle.
  - Further edges keep shifting FILL_BIT; no pulse and no wrap.
- Simultaneous synced latch = 1 and a clk rising edge: load wins and no shift occurs.
- Outputs: jp_dataN_out = srN[0], driven straight from flops with no combinational path from inputs.
- Latency: an input edge on jp_clk_in or jp_latch_in changes jp_dataN_out on clk_in edge SYNC_STAGES+1 after the input change (3 cycles at default).
- Button changes during SHIFT have no effect until the next latch.
- Reset mid-read: all state returns to reset values within that cycle. The next read requires a new latch.
- Latch pulses shorter than SYNC_STAGES cycles are not guaranteed to be seen. The rp2a03 holds latch for at least 1 CPU cycle, well above this.

Optional Feature:
JOYPAD_TURBO_EN:
- Defined:
  - Adds ports turbo1_in and turbo2_in.
  - Adds a counter of synced latch falling edges. The turbo phase toggles every TURBO_FRAMES falling edges and the counter wraps to 0.
  - When turbo bit k is set and phase = 0, button k (A or B) is masked to 0 before load. When phase = 1 the button passes through.
  - Counter and phase reset to 0.
- Undefined: the turbo ports, counter and masking are absent and buttons load unmodified after SOCD filtering.

Test Plan:
- Reset, then hold latch low and pulse jp_clk 3 times -> data1/data2 stay 0 and read_done_out is never asserted.
- Set btn1 = 8'b1000_0101 and btn2 = 8'h00. Latch high 4 cycles, then low; 8 clk pulses -> data1 reads 1,0,1,0,0,0,0,1 and data2 reads all 0. read_done_out pulses once on the 8th shift.
- After the 8th shift, apply 4 more clk pulses -> data1 = data2 = 1 each time (FILL_BIT) and no extra read_done_out.
- Set btn1 = 8'b0011_0000 (Up+Down) with SOCD_FILTER = 1, latch, then shift -> bits 4 and 5 read 0. With SOCD_FILTER = 0 they read 1.
- Raise latch in the same cycle as a clk rising edge mid-read -> registers reload and data1 = btn1[0]. Assert rst_in mid-read -> outputs 0 on the next cycle.
- With JOYPAD_TURBO_EN, TURBO_FRAMES = 2, turbo1_in = 2'b01 and A held: A reads 0,0,1,1,0 over frames 1-5. It reads 1 in every frame with turbo1_in = 0.
